cart_dongle_bridge: RTL and testbench

Bus-side front end for the cartridge-port copy-protection dongle. Decodes 68000 read cycles into the cartridge ROM window (0xFA0000–0xFBFFFF), presents A[8:1] and a qualified upper-data-strobe to the downstream dongle, and returns the dongle's upper byte to the CPU with a registered select and DTACK. The downstream dongle advances its state on the rising edge of the strobe; this block guarantees exactly one rising edge per claimed upper-byte read.

---
 rtl/cart_pkg.sv | 18 +
 rtl/cart_dongle_bridge.sv | 106 ++++++++++
 tb/tb_cart_dongle_bridge.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
// Shared types and defaults for the cartridge-port dongle bridge.
package cart_pkg;

    // Bus-cycle tracking states of the bridge
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        END  = 2'd2
    } cart_state_t;

    // cpu_a[23:17] value selecting the 0xFA0000-0xFBFFFF window
    localparam logic [6:0]  CART_WIN_HI   = 7'b1111101;
    // Lower byte returned on claimed reads
    localparam logic [7:0]  CART_LO_BYTE  = 8'hFF;
    // Idle / reset value of the CPU read data
    localparam logic [15:0] CART_DOUT_RST = 16'hFFFF;

endpackage

// File: rtl/cart_dongle_bridge.sv
// Bus-side front end for the cartridge copy-protection dongle.
// Claims 68000 read cycles in the cartridge ROM window, forwards A[8:1] and a
// qualified UDS to the dongle, and returns its upper byte with DTACK.
// Optional macro CART_DONGLE_STATS_EN enables the access_cnt strobe counter.
module cart_dongle_bridge
    import cart_pkg::*;
#(
    parameter logic [6:0] WIN_HI  = CART_WIN_HI,
    parameter logic [7:0] LO_BYTE = CART_LO_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dongle_en,
    input  logic [23:1] cpu_a,
    input  logic        cpu_as_n,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic        cpu_rw,
    output logic        cpu_sel,
    output logic [15:0] cpu_dout,
    output logic        cpu_dtack_n,
    output logic [7:0]  dongle_a,
    output logic        dongle_uds_n,
    input  logic [7:0]  dongle_d,
    output logic [15:0] access_cnt
);

    cart_state_t state;
    logic        armed;
    logic        claim;
    logic        unused_a;

    // Only A[23:17] and A[8:1] participate in decode and forwarding
    assign unused_a = ^cpu_a[16:9];

    // New bus cycle into the window that this block may take
    always_comb begin
        claim = 1'b0;
        if (!cpu_as_n && armed && cpu_rw && dongle_en &&
            (cpu_a[23:17] == WIN_HI) && (!cpu_uds_n || !cpu_lds_n))
            claim = 1'b1;
    end

    // Bus-cycle FSM with registered CPU and dongle outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            armed        <= 1'b0;
            cpu_sel      <= 1'b0;
            cpu_dtack_n  <= 1'b1;
            cpu_dout     <= CART_DOUT_RST;
            dongle_a     <= 8'h00;
            dongle_uds_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (claim) begin
                        state        <= READ;
                        armed        <= 1'b0;
                        dongle_a     <= cpu_a[8:1];
                        dongle_uds_n <= cpu_uds_n;
                    end else begin
                        // Any unclaimed low-AS cycle disarms until AS rises
                        armed <= cpu_as_n;
                    end
                end
                READ: begin
                    if (cpu_as_n) begin
                        state        <= END;
                        armed        <= 1'b1;
                        cpu_sel      <= 1'b0;
                        cpu_dtack_n  <= 1'b1;
                        cpu_dout     <= CART_DOUT_RST;
                        dongle_uds_n <= 1'b1;
                    end else begin
                        cpu_sel     <= 1'b1;
                        cpu_dtack_n <= 1'b0;
                        cpu_dout    <= {dongle_d, LO_BYTE};
                    end
                end
                END: begin
                    // armed from the AS-high edge survives a fast re-assert
                    state <= IDLE;
                    if (cpu_as_n)
                        armed <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CART_DONGLE_STATS_EN
    // Count strobe rises delivered to the dongle on READ->END
    always_ff @(posedge clk) begin
        if (reset)
            access_cnt <= 16'h0000;
        else if ((state == READ) && cpu_as_n && !dongle_uds_n)
            access_cnt <= access_cnt + 16'd1;
    end
`else
    assign access_cnt = '0;
`endif

endmodule

// File: tb/tb_cart_dongle_bridge.sv
// Directed self-checking bench for cart_dongle_bridge.
module tb_cart_dongle_bridge;

`ifdef CART_DONGLE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        dongle_en;
    logic [23:1] cpu_a;
    logic        cpu_as_n;
    logic        cpu_uds_n;
    logic        cpu_lds_n;
    logic        cpu_rw;
    logic        cpu_sel;
    logic [15:0] cpu_dout;
    logic        cpu_dtack_n;
    logic [7:0]  dongle_a;
    logic        dongle_uds_n;
    logic [7:0]  dongle_d;
    logic [15:0] access_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] exp_cnt = 16'h0000;

    cart_dongle_bridge #(.WIN_HI(7'b1111101), .LO_BYTE(8'hFF)) dut (
        .clk(clk), .reset(reset), .dongle_en(dongle_en), .cpu_a(cpu_a),
        .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
        .cpu_rw(cpu_rw), .cpu_sel(cpu_sel), .cpu_dout(cpu_dout),
        .cpu_dtack_n(cpu_dtack_n), .dongle_a(dongle_a),
        .dongle_uds_n(dongle_uds_n), .dongle_d(dongle_d),
        .access_cnt(access_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        cpu_rw    = 1'b1;
    endtask

    task automatic bus_start(input logic [23:0] addr, input logic rw,
                             input logic uds_n, input logic lds_n);
        cpu_a     = addr[23:1];
        cpu_rw    = rw;
        cpu_uds_n = uds_n;
        cpu_lds_n = lds_n;
        cpu_as_n  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (cpu_sel !== 1'b0) begin
            errors++; $display("FAIL %s_sel actual=%b expected=0", tag, cpu_sel);
        end
        checks++;
        if (cpu_dtack_n !== 1'b1) begin
            errors++; $display("FAIL %s_dtack actual=%b expected=1", tag, cpu_dtack_n);
        end
        checks++;
        if (cpu_dout !== 16'hFFFF) begin
            errors++; $display("FAIL %s_dout actual=%h expected=ffff", tag, cpu_dout);
        end
        checks++;
        if (dongle_uds_n !== 1'b1) begin
            errors++; $display("FAIL %s_uds actual=%b expected=1", tag, dongle_uds_n);
        end
        checks++;
        if (access_cnt !== exp_cnt) begin
            errors++; $display("FAIL %s_cnt actual=%h expected=%h", tag, access_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        dongle_en = 1'b1;
        dongle_d = 8'h00;
        cpu_a = '0;
        bus_idle();
        tick();
        tick();
        exp_cnt = 16'h0000;
        check_idle_outputs("reset");
        checks++;
        if (dongle_a !== 8'h00) begin
            errors++; $display("FAIL reset_da actual=%h expected=00", dongle_a);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_word_read;
        bus_idle();
        tick();
        dongle_d = 8'h5A;
        bus_start(24'hFB01B0, 1'b1, 1'b0, 1'b0);
        tick();  // E0
        checks++;
        if (dongle_a !== 8'hD8) begin
            errors++; $display("FAIL word_da actual=%h expected=d8", dongle_a);
        end
        checks++;
        if (dongle_uds_n !== 1'b0) begin
            errors++; $display("FAIL word_uds_e0 actual=%b expected=0", dongle_uds_n);
        end
        checks++;
        if (cpu_sel !== 1'b0) begin
            errors++; $display("FAIL word_sel_e0 actual=%b expected=0", cpu_sel);
        end
        tick();  // E1
        checks++;
        if (cpu_sel !== 1'b1 || cpu_dtack_n !== 1'b0) begin
            errors++; $display("FAIL word_ack actual=%b%b expected=10", cpu_sel, cpu_dtack_n);
        end
        checks++;
        if (cpu_dout !== 16'h5AFF) begin
            errors++; $display("FAIL word_dout actual=%h expected=5aff", cpu_dout);
        end
        dongle_d = 8'h33;
        tick();
        checks++;
        if (cpu_dout !== 16'h33FF) begin
            errors++; $display("FAIL word_track actual=%h expected=33ff", cpu_dout);
        end
        checks++;
        if (dongle_uds_n !== 1'b0) begin
            errors++; $display("FAIL word_uds_hold actual=%b expected=0", dongle_uds_n);
        end
        bus_idle();
        tick();  // Ek
        if (STATS) exp_cnt = exp_cnt + 16'd1;
        check_idle_outputs("word_end");
        checks++;
        if (dongle_a !== 8'hD8) begin
            errors++; $display("FAIL word_da_hold actual=%h expected=d8", dongle_a);
        end
        tick();
    endtask

    task automatic test_no_claim;
        bus_idle();
        tick();
        bus_start(24'hE00000, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick();
        check_idle_outputs("miss_read");
        bus_idle();
        tick();
        bus_start(24'hFA0002, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        check_idle_outputs("write");
        checks++;
        if (dongle_a !== 8'hD8) begin
            errors++; $display("FAIL write_da actual=%h expected=d8", dongle_a);
        end
        bus_idle();
        tick();
        dongle_en = 1'b0;
        bus_start(24'hFA0000, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick();
        check_idle_outputs("disabled");
        dongle_en = 1'b1;
        bus_idle();
        tick();
    endtask

    task automatic test_lds_only;
        bus_idle();
        tick();
        dongle_d = 8'hC3;
        bus_start(24'hFA0010, 1'b1, 1'b1, 1'b0);
        tick();  // E0
        checks++;
        if (dongle_a !== 8'h08 || dongle_uds_n !== 1'b1) begin
            errors++; $display("FAIL lds_e0 actual=%h/%b expected=08/1", dongle_a, dongle_uds_n);
        end
        tick();  // E1
        checks++;
        if (cpu_dout !== 16'hC3FF || cpu_dtack_n !== 1'b0 || cpu_sel !== 1'b1) begin
            errors++; $display("FAIL lds_data actual=%h/%b/%b expected=c3ff/0/1",
                               cpu_dout, cpu_dtack_n, cpu_sel);
        end
        checks++;
        if (dongle_uds_n !== 1'b1) begin
            errors++; $display("FAIL lds_uds actual=%b expected=1", dongle_uds_n);
        end
        bus_idle();
        tick();
        check_idle_outputs("lds_end");
        tick();
    endtask

    task automatic test_back_to_back;
        bus_idle();
        tick();
        dongle_d = 8'h11;
        bus_start(24'hFA0002, 1'b1, 1'b0, 1'b0);
        tick();  // E0
        tick();  // E1
        checks++;
        if (cpu_dout !== 16'h11FF || dongle_a !== 8'h01) begin
            errors++; $display("FAIL b2b_first actual=%h/%h expected=11ff/01", cpu_dout, dongle_a);
        end
        bus_idle();
        tick();  // Ek
        if (STATS) exp_cnt = exp_cnt + 16'd1;
        check_idle_outputs("b2b_end1");
        dongle_d = 8'h22;
        bus_start(24'hFA0004, 1'b1, 1'b0, 1'b0);
        tick();  // Ek+1, END -> IDLE
        checks++;
        if (dongle_uds_n !== 1'b1 || cpu_sel !== 1'b0) begin
            errors++; $display("FAIL b2b_gap actual=%b/%b expected=1/0", dongle_uds_n, cpu_sel);
        end
        tick();  // Ek+2, second claim
        checks++;
        if (dongle_uds_n !== 1'b0 || dongle_a !== 8'h02) begin
            errors++; $display("FAIL b2b_claim2 actual=%b/%h expected=0/02", dongle_uds_n, dongle_a);
        end
        tick();
        checks++;
        if (cpu_dout !== 16'h22FF || cpu_dtack_n !== 1'b0) begin
            errors++; $display("FAIL b2b_data2 actual=%h/%b expected=22ff/0", cpu_dout, cpu_dtack_n);
        end
        dongle_en = 1'b0;  // mid-cycle drop must not abort the cycle
        tick();
        checks++;
        if (cpu_sel !== 1'b1 || cpu_dtack_n !== 1'b0) begin
            errors++; $display("FAIL b2b_en_drop actual=%b/%b expected=1/0", cpu_sel, cpu_dtack_n);
        end
        bus_idle();
        tick();
        if (STATS) exp_cnt = exp_cnt + 16'd1;
        check_idle_outputs("b2b_end2");
        dongle_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_read;
        bus_idle();
        tick();
        dongle_d = 8'h77;
        bus_start(24'hFB0040, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        checks++;
        if (cpu_sel !== 1'b1 || dongle_a !== 8'h20) begin
            errors++; $display("FAIL rst_pre actual=%b/%h expected=1/20", cpu_sel, dongle_a);
        end
        reset = 1'b1;
        tick();
        exp_cnt = 16'h0000;
        check_idle_outputs("rst_mid");
        checks++;
        if (dongle_a !== 8'h00) begin
            errors++; $display("FAIL rst_mid_da actual=%h expected=00", dongle_a);
        end
        reset = 1'b0;
        bus_idle();
        tick();
        dongle_d = 8'h99;
        bus_start(24'hFA0006, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (dongle_a !== 8'h03 || dongle_uds_n !== 1'b0) begin
            errors++; $display("FAIL rst_after_e0 actual=%h/%b expected=03/0", dongle_a, dongle_uds_n);
        end
        tick();
        checks++;
        if (cpu_dout !== 16'h99FF || cpu_dtack_n !== 1'b0) begin
            errors++; $display("FAIL rst_after_data actual=%h/%b expected=99ff/0", cpu_dout, cpu_dtack_n);
        end
        bus_idle();
        tick();
        if (STATS) exp_cnt = exp_cnt + 16'd1;
        check_idle_outputs("rst_after_end");
        tick();
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_no_claim();
        test_lds_only();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
